// File: rtl/fp16_vec_pack_16_if.sv
// Handshake bundle between the FP16 scalar stream, the packer and the 16-to-1 reduction tree.
interface fp16_vec_pack_16_if #(
  parameter int LANES = 16,
  parameter int DW    = 16
);
  localparam int CW = $clog2(LANES) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*DW-1:0]   out_vec;
  logic [CW-1:0]         out_lanes;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_vec, out_lanes
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_vec, out_lanes
  );
endinterface

// File: rtl/fp16_vec_pack_16.sv
// Serial-to-parallel FP16 packer: assembles 16 scalars into one vector, double-buffered.
// Optional short-group zero padding on in_last is enabled by defining PACK_ZERO_PAD_EN.
module fp16_vec_pack_16 #(
  parameter int LANES = 16,
  parameter int DW    = 16
) (
  input  logic               clk,
  input  logic               rst,
  fp16_vec_pack_16_if.slave  bus
);
  localparam int CW = $clog2(LANES) + 1;
  localparam logic [CW-1:0] FULL = CW'(LANES);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  logic [CW-1:0]       cnt;
  logic [LANES*DW-1:0] asm_q;
  logic [LANES*DW-1:0] asm_vec;
  logic                out_valid_q;
  logic [LANES*DW-1:0] out_vec_q;
  logic [CW-1:0]       out_lanes_q;
  logic [CW-1:0]       held_lanes;
  logic                accept;
  logic                close_grp;
  logic                complete;
  logic                free;
  logic                pending;

  assign bus.in_ready  = (cnt != FULL);
  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = out_vec_q;
  assign bus.out_lanes = out_lanes_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign complete = accept && close_grp;
  assign free     = !out_valid_q || bus.out_ready;
  assign pending  = (cnt == FULL);

`ifdef PACK_ZERO_PAD_EN
  logic [CW-1:0] pend_lanes;

  assign close_grp  = (cnt == LAST) || bus.in_last;
  assign held_lanes = pend_lanes;

  // Lanes past the closing beat may hold stale data from an earlier group; mask them to +0.0.
  always_comb begin
    asm_vec = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (CW'(k) < cnt)
        asm_vec[k*DW +: DW] = asm_q[k*DW +: DW];
      else if (CW'(k) == cnt)
        asm_vec[k*DW +: DW] = bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pend_lanes <= '0;
    else if (complete && !free)
      pend_lanes <= cnt + 1'b1;
  end
`else
  logic in_last_unused;

  assign in_last_unused = bus.in_last;
  assign close_grp      = (cnt == LAST);
  assign held_lanes     = FULL;
  assign asm_vec        = {bus.in_data, asm_q[(LANES-1)*DW-1:0]};
`endif

  // Priority: direct completion, then park a completed vector, then drain the parked one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      asm_q       <= '0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      out_lanes_q <= '0;
    end else if (complete && free) begin
      out_vec_q   <= asm_vec;
      out_lanes_q <= cnt + 1'b1;
      out_valid_q <= 1'b1;
      cnt         <= '0;
    end else if (complete) begin
      asm_q <= asm_vec;
      cnt   <= FULL;
    end else if (pending && free) begin
      out_vec_q   <= asm_q;
      out_lanes_q <= held_lanes;
      out_valid_q <= 1'b1;
      cnt         <= '0;
    end else begin
      if (accept) begin
        asm_q[cnt*DW +: DW] <= bus.in_data;
        cnt                 <= cnt + 1'b1;
      end
      if (bus.out_ready)
        out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fp16_vec_pack_16.sv
// Directed and random-stall bench for fp16_vec_pack_16 with an in-order vector scoreboard.
module tb_fp16_vec_pack_16;
`ifdef PACK_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_fired  = 0;

  logic [15:0]  m_beats[$];
  logic [255:0] exp_vec_q[$];
  logic [4:0]   exp_lanes_q[$];

  fp16_vec_pack_16_if #(.LANES(16), .DW(16)) bus ();

  fp16_vec_pack_16 #(.LANES(16), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] ramp(input logic [15:0] base, input int n);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 16; k++)
      if (k < n) v[k*16 +: 16] = base + 16'(k);
    return v;
  endfunction

  // Scoreboard: rebuilds each group from accepted beats, compares every consumed vector in order.
  always @(negedge clk) begin
    if (rst) begin
      m_beats.delete();
      exp_vec_q.delete();
      exp_lanes_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_fired++;
        check("sb_nonempty", 256'(exp_vec_q.size() != 0), 256'(1));
        if (exp_vec_q.size() != 0) begin
          check("sb_vec", bus.out_vec, exp_vec_q.pop_front());
          check("sb_lanes", 256'(bus.out_lanes), 256'(exp_lanes_q.pop_front()));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        m_beats.push_back(bus.in_data);
        if (m_beats.size() == 16 || (PAD && bus.in_last)) begin
          logic [255:0] v;
          v = '0;
          foreach (m_beats[i]) v[i*16 +: 16] = m_beats[i];
          exp_vec_q.push_back(v);
          exp_lanes_q.push_back(5'(m_beats.size()));
          m_beats.delete();
        end
      end
    end
  end

  initial begin
    logic [255:0] exp_v;
    int           drops;
    int           target;
    int           cycles;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready", 256'(bus.in_ready), 256'(1));
    check("rst_out_valid", 256'(bus.out_valid), 256'(0));
    check("rst_out_vec", bus.out_vec, 256'(0));
    check("rst_out_lanes", 256'(bus.out_lanes), 256'(0));
    tick();

    // Full vector then a back-to-back second group.
    bus.out_ready = 1'b1;
    drops = 0;
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h3C00 + 16'(k);
      if (bus.in_ready !== 1'b1) drops++;
      check("full_no_early_valid", 256'(bus.out_valid), 256'(0));
      tick();
    end
    check("full_valid", 256'(bus.out_valid), 256'(1));
    check("full_vec", bus.out_vec, ramp(16'h3C00, 16));
    check("full_lanes", 256'(bus.out_lanes), 256'(16));
    for (int k = 0; k < 16; k++) begin
      bus.in_data = 16'h5000 + 16'(k);
      if (bus.in_ready !== 1'b1) drops++;
      tick();
    end
    check("stream_no_ready_drop", 256'(drops), 256'(0));
    check("stream_valid", 256'(bus.out_valid), 256'(1));
    check("stream_vec", bus.out_vec, ramp(16'h5000, 16));
    bus.in_valid = 1'b0;
    tick();
    check("consumed_valid", 256'(bus.out_valid), 256'(0));

    // Short group closed by in_last on the fifth beat.
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h4000;
      bus.in_last  = (k == 4);
      tick();
    end
    bus.in_last = 1'b0;
`ifdef PACK_ZERO_PAD_EN
    bus.in_valid = 1'b0;
    exp_v = '0;
    for (int k = 0; k < 5; k++) exp_v[k*16 +: 16] = 16'h4000;
    check("short_valid", 256'(bus.out_valid), 256'(1));
    check("short_vec", bus.out_vec, exp_v);
    check("short_lanes", 256'(bus.out_lanes), 256'(5));
`else
    check("short_no_valid", 256'(bus.out_valid), 256'(0));
    for (int k = 0; k < 11; k++) begin
      bus.in_data = 16'h4100 + 16'(k);
      tick();
      if (k < 10) check("short_still_no_valid", 256'(bus.out_valid), 256'(0));
    end
    bus.in_valid = 1'b0;
    exp_v = '0;
    for (int k = 0; k < 16; k++)
      exp_v[k*16 +: 16] = (k < 5) ? 16'h4000 : 16'h4100 + 16'(k - 5);
    check("short_fill_valid", 256'(bus.out_valid), 256'(1));
    check("short_fill_vec", bus.out_vec, exp_v);
    check("short_fill_lanes", 256'(bus.out_lanes), 256'(16));
`endif
    tick();

    // Backpressure: 40 cycles of out_ready low with a continuous stream.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 40; c++) begin
      bus.in_data = 16'h6000 + 16'(c);
      check("bp_in_ready", 256'(bus.in_ready), 256'(c < 32));
      if (c == 20 || c == 39) begin
        check("bp_hold_valid", 256'(bus.out_valid), 256'(1));
        check("bp_hold_vec", bus.out_vec, ramp(16'h6000, 16));
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_second_valid", 256'(bus.out_valid), 256'(1));
    check("bp_second_vec", bus.out_vec, ramp(16'h6010, 16));
    check("bp_ready_back", 256'(bus.in_ready), 256'(1));
    bus.out_ready = 1'b1;
    tick();
    check("bp_drained", 256'(bus.out_valid), 256'(0));

    // Reset mid-group, then reset while a vector is presented.
    for (int k = 0; k < 7; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h7000 + 16'(k);
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", 256'(bus.in_ready), 256'(1));
    check("rst_mid_out_valid", 256'(bus.out_valid), 256'(0));
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h7100 + 16'(k);
      tick();
    end
    bus.in_valid = 1'b0;
    check("rst_clean_valid", 256'(bus.out_valid), 256'(1));
    check("rst_clean_vec", bus.out_vec, ramp(16'h7100, 16));
    rst = 1'b1;
    #1;
    check("rst_pres_out_valid", 256'(bus.out_valid), 256'(0));
    check("rst_pres_out_vec", bus.out_vec, 256'(0));
    check("rst_pres_in_ready", 256'(bus.in_ready), 256'(1));
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h7200 + 16'(k);
      tick();
    end
    bus.in_valid = 1'b0;
    check("rst_after_vec", bus.out_vec, ramp(16'h7200, 16));
    tick();

    // Random stalls on both sides; the scoreboard checks every consumed vector.
    target = n_fired + 300;
    cycles = 0;
    while (n_fired < target && cycles < 40000) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_data   = 16'($urandom);
      bus.in_last   = ($urandom_range(0, 7) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      tick();
      cycles++;
    end
    check("rand_done", 256'(n_fired >= target), 256'(1));
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    check("rand_all_consumed", 256'(exp_vec_q.size()), 256'(0));
    check("rand_out_idle", 256'(bus.out_valid), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
